alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU for the MIPS-lite datapath. Registered single-cycle ops
//  (add/sub/logic/compare/shift) plus iterative multiply/divide writing a HI/LO pair.
//  Sits in EX stage; the controller stalls the pipe while busy=1.
// PARAMETERS
//  WIDTH     32  operand/result width (>=8, even)
//  CNT_W     6   iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk       in   1        rising-edge clock
//  rst       in   1        asynchronous reset, active-high
//  start     in   1        op request; accepted only when busy=0
//  ctl       in   4        0 add,1 sub,2 and,3 or,4 xor,5 slt,6 sltu,7 sll,8 srl,9 sra,
//                          10 mult,11 multu,12 div,13 divu; 14,15 reserved
//  a, b      in   WIDTH    operands (shift amount = b[log2(WIDTH)-1:0], shifts a)
//  out       out  WIDTH    result of ops 0-9; LO copy for ops 10-13
//  hi, lo    out  WIDTH    mul: {hi,lo}=a*b; div: lo=quotient, hi=remainder
//  zero      out  1        1 when a==b at accept (BEQ/BNE)
//  overflow  out  1        signed overflow of add/sub (see CONFIGURATION)
//  busy      out  1        1 while an op is in flight
//  done      out  1        one-cycle pulse, results valid same cycle
// BEHAVIOUR
//  - Clock/reset: one clock; reset is asynchronous and active-high. Reset: all outputs 0, state IDLE.
//  - FSM: IDLE -> (start, ctl<=9) -> FIN; IDLE -> (start, ctl 10-13) -> ITER;
//    ITER -> (count==WIDTH-1) -> FIX; FIX -> FIN; FIN -> IDLE. done=1 only in FIN.
//  - a, b, ctl captured at accept edge; later input changes do not affect the op.
//  - Latency: ops 0-9 done 1 cycle after accept; ops 10-13 done WIDTH+2 cycles after.
//  - busy=1 from the cycle after accept through the cycle before FIN; so start is accepted
//    in the FIN cycle (back-to-back). start while busy=1 is ignored, no queueing.
//  - ctl 14/15: complete as 1-cycle ops, out=0, hi/lo unchanged.
//  - add/sub wrap modulo 2**WIDTH. slt/sltu: out = {WIDTH-1 zeros, flag}. sra sign-fills.
//  - mult/div signed: operate on magnitudes, ITER = shift-add / restoring-subtract,
//    FIX negates per sign rules (quotient sign = a^b, remainder sign = a).
//  - div by zero: lo = all ones, hi = a (unsigned and signed); no trap, normal latency.
//  - Signed div of most-negative by -1: lo = most-negative, hi = 0.
//  - hi/lo update only at FIN of ops 10-13; hold otherwise. out, zero, overflow update
//    at every FIN and hold until next FIN.
//  - Reset asserted mid-op: abort immediately, no done pulse, outputs cleared.
// CONFIGURATION
//  ALU_OVERFLOW_EN defined: overflow = signed overflow of op 0/1 (operand signs per op,
//   result sign differs); 0 for all other ops; registered with out.
//  Not defined: overflow tied to 0, no overflow logic synthesised.
// TESTING
//  1 start, ctl=0, a=32'h7FFF_FFFF, b=1 -> next cycle done=1, out=32'h8000_0000,
//    overflow=1 (with ALU_OVERFLOW_EN) / 0 (without), zero=0.
//  2 ctl=10, a=-3, b=7 -> done exactly 34 cycles after accept, {hi,lo}=64'hFFFF_FFFF_FFFF_FFEB,
//    busy=1 in between; a 2nd start mid-op is ignored.
//  3 ctl=13, a=100, b=7 -> lo=14, hi=2; ctl=12, a=-7, b=2 -> lo=-3, hi=-1.
//  4 ctl=13, b=0, a=5 -> lo=32'hFFFF_FFFF, hi=5; ctl=12 a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
//  5 ctl=9, a=32'hF000_0000, b=4 -> out=32'hFF00_0000; ctl=6, a=1, b=-1 -> out=1; ctl=5 -> out=0.
//  6 rst pulse during ITER (cycle 10 of mult) -> outputs 0, busy=0, no done; next op runs normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq: the controller drives the master side, the ALU is the slave.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, ctl, a, b,
        input  out, hi, lo, zero, overflow, busy, done
    );

    modport slave (
        input  start, ctl, a, b,
        output out, hi, lo, zero, overflow, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative mul/div into HI/LO.
// Define ALU_OVERFLOW_EN to build the signed add/sub overflow flag; otherwise overflow is tied to 0.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave s
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, FIX, FIN} state_t;
    state_t state, state_n;

    logic                 accept;
    logic                 is_md;
    logic                 is_div;
    logic                 is_signed;
    logic [3:0]           op;
    logic [WIDTH-1:0]     ra, rb, md;
    logic [2*WIDTH-1:0]   p, p_step;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     sum, diff, res;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [SHW-1:0]       sh;
    logic [WIDTH:0]       madd, rs, rsub;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     q, r, hi_f, lo_f;
    logic                 op_div;

    assign accept    = s.start && (state == IDLE || state == FIN);
    assign is_md     = (s.ctl >= 4'd10) && (s.ctl <= 4'd13);
    assign is_div    = (s.ctl == 4'd12) || (s.ctl == 4'd13);
    assign is_signed = (s.ctl == 4'd10) || (s.ctl == 4'd12);
    assign op_div    = (op == 4'd12) || (op == 4'd13);

    assign s.busy = (state == ITER) || (state == FIX);
    assign s.done = (state == FIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = is_md ? ITER : FIN;
            ITER:    if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
            FIX:     state_n = FIN;
            FIN:     state_n = accept ? (is_md ? ITER : FIN) : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Single-cycle results straight from the live operands; registered at accept.
    always_comb begin
        sum  = s.a + s.b;
        diff = s.a - s.b;
        sh   = s.b[SHW-1:0];
        res  = '0;
        case (s.ctl)
            4'd0:    res = sum;
            4'd1:    res = diff;
            4'd2:    res = s.a & s.b;
            4'd3:    res = s.a | s.b;
            4'd4:    res = s.a ^ s.b;
            4'd5:    res = {{(WIDTH-1){1'b0}}, ($signed(s.a) < $signed(s.b))};
            4'd6:    res = {{(WIDTH-1){1'b0}}, (s.a < s.b)};
            4'd7:    res = s.a << sh;
            4'd8:    res = s.a >> sh;
            4'd9:    res = $signed(s.a) >>> sh;
            default: res = '0;
        endcase
    end

    assign mag_a = (is_signed && s.a[WIDTH-1]) ? (~s.a + 1'b1) : s.a;
    assign mag_b = (is_signed && s.b[WIDTH-1]) ? (~s.b + 1'b1) : s.b;

    // p holds {acc, multiplier} for mul and {remainder, quotient} for div.
    always_comb begin
        madd = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, md};
        rs   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        rsub = rs - {1'b0, md};
        if (op_div)
            p_step = (rs >= {1'b0, md}) ? {rsub[WIDTH-1:0], p[WIDTH-2:0], 1'b1}
                                        : {rs[WIDTH-1:0],   p[WIDTH-2:0], 1'b0};
        else
            p_step = p[0] ? {madd, p[WIDTH-1:1]} : {1'b0, p[2*WIDTH-1:1]};
    end

    always_comb begin
        prod = (op == 4'd10 && (ra[WIDTH-1] ^ rb[WIDTH-1])) ? (~p + 1'b1) : p;
        q    = p[WIDTH-1:0];
        r    = p[2*WIDTH-1:WIDTH];
        if (op == 4'd12) begin
            if (ra[WIDTH-1] ^ rb[WIDTH-1]) q = ~q + 1'b1;
            if (ra[WIDTH-1])               r = ~r + 1'b1;
        end
        if (rb == '0) begin
            q = '1;
            r = ra;
        end
        hi_f = op_div ? r : prod[2*WIDTH-1:WIDTH];
        lo_f = op_div ? q : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op  <= '0;
            ra  <= '0;
            rb  <= '0;
            md  <= '0;
            p   <= '0;
            cnt <= '0;
        end else if (accept && is_md) begin
            op  <= s.ctl;
            ra  <= s.a;
            rb  <= s.b;
            cnt <= '0;
            md  <= is_div ? mag_b : mag_a;
            p   <= {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end else if (state == ITER) begin
            p   <= p_step;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s.out  <= '0;
            s.hi   <= '0;
            s.lo   <= '0;
            s.zero <= 1'b0;
        end else if (accept && !is_md) begin
            s.out  <= res;
            s.zero <= (s.a == s.b);
        end else if (state == FIX) begin
            s.out  <= lo_f;
            s.hi   <= hi_f;
            s.lo   <= lo_f;
            s.zero <= (ra == rb);
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_n;

    always_comb begin
        ovf_n = 1'b0;
        if (s.ctl == 4'd0)
            ovf_n = (s.a[WIDTH-1] == s.b[WIDTH-1]) && (sum[WIDTH-1] != s.a[WIDTH-1]);
        else if (s.ctl == 4'd1)
            ovf_n = (s.a[WIDTH-1] != s.b[WIDTH-1]) && (diff[WIDTH-1] != s.a[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   s.overflow <= 1'b0;
        else if (accept && !is_md) s.overflow <= ovf_n;
        else if (state == FIX)     s.overflow <= 1'b0;
    end
`else
    assign s.overflow = 1'b0;
`endif
endmodule
